// File: rtl/sort_frame_loader.sv
// rtl/sort_frame_loader.sv - double-banked 8-entry frame assembler feeding the low-nibble sort network
// Fill bank assembles the incoming frame while the hold bank presents the previous one.
module sort_frame_loader #(
  parameter int                 DATA_W    = 8,
  parameter logic [DATA_W-1:0]  PAD_VALUE = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] num0,
  output logic [DATA_W-1:0] num1,
  output logic [DATA_W-1:0] num2,
  output logic [DATA_W-1:0] num3,
  output logic [DATA_W-1:0] num4,
  output logic [DATA_W-1:0] num5,
  output logic [DATA_W-1:0] num6,
  output logic [DATA_W-1:0] num7,
  output logic              frame_valid,
  input  logic              frame_ack,
  output logic [3:0]        frame_len,
  output logic [15:0]       frame_count
);

  typedef enum logic {FILL, WAIT} state_t;

  state_t            state_q;
  logic [2:0]        idx_q;
  logic [3:0]        pend_len_q;
  logic [DATA_W-1:0] fill_q [8];
  logic [DATA_W-1:0] fill_d [8];
  logic [DATA_W-1:0] num_q  [8];
  logic [3:0]        frame_len_q;
  logic [3:0]        len_d;
  logic              frame_valid_q;
  logic [15:0]       frame_count_q;

  logic accept;
  logic complete;
  logic hold_free;
  logic transfer;

  assign in_ready  = rst_n && (state_q == FILL);
  assign accept    = in_valid && in_ready;
  assign complete  = accept && ((idx_q == 3'd7) || in_last);
  assign hold_free = !frame_valid_q || frame_ack;
  assign transfer  = ((state_q == FILL) && complete && hold_free) ||
                     ((state_q == WAIT) && frame_ack);
  assign len_d     = (state_q == WAIT) ? pend_len_q : ({1'b0, idx_q} + 4'd1);

  // Padding is applied as the frame closes, so fill_d is always the finished frame on a transfer.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      fill_d[i] = fill_q[i];
      if (accept) begin
        if (3'(i) == idx_q) begin
          fill_d[i] = in_data;
        end else if (complete && (3'(i) > idx_q)) begin
          fill_d[i] = PAD_VALUE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      idx_q         <= 3'd0;
      pend_len_q    <= 4'd0;
      frame_len_q   <= 4'd0;
      frame_valid_q <= 1'b0;
      frame_count_q <= 16'd0;
      for (int i = 0; i < 8; i++) begin
        fill_q[i] <= '0;
        num_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        fill_q[i] <= fill_d[i];
      end
      if (transfer) begin
        for (int i = 0; i < 8; i++) begin
          num_q[i] <= fill_d[i];
        end
        frame_len_q   <= len_d;
        frame_valid_q <= 1'b1;
        frame_count_q <= frame_count_q + 16'd1;
        idx_q         <= 3'd0;
        state_q       <= FILL;
      end else begin
        if (frame_ack && frame_valid_q) begin
          frame_valid_q <= 1'b0;
        end
        // A completed frame with a busy hold bank parks in the fill bank until acked.
        if (complete) begin
          pend_len_q <= len_d;
          state_q    <= WAIT;
        end else if (accept) begin
          idx_q <= idx_q + 3'd1;
        end
      end
    end
  end

  assign num0        = num_q[0];
  assign num1        = num_q[1];
  assign num2        = num_q[2];
  assign num3        = num_q[3];
  assign num4        = num_q[4];
  assign num5        = num_q[5];
  assign num6        = num_q[6];
  assign num7        = num_q[7];
  assign frame_valid = frame_valid_q;
  assign frame_len   = frame_len_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_sort_frame_loader.sv
// tb/tb_sort_frame_loader.sv - directed self-checking bench for sort_frame_loader
module tb_sort_frame_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] num0, num1, num2, num3, num4, num5, num6, num7;
  logic       frame_valid;
  logic       frame_ack;
  logic [3:0] frame_len;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sort_frame_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .num0        (num0),
    .num1        (num1),
    .num2        (num2),
    .num3        (num3),
    .num4        (num4),
    .num5        (num5),
    .num6        (num6),
    .num7        (num7),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .frame_len   (frame_len),
    .frame_count (frame_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last, input logic ack);
    in_data   = d;
    in_last   = last;
    in_valid  = 1'b1;
    frame_ack = ack;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    frame_ack = 1'b0;
  endtask

  task automatic pulse_ack();
    frame_ack = 1'b1;
    @(posedge clk);
    #1;
    frame_ack = 1'b0;
  endtask

  initial begin
    logic [7:0] f2 [8];
    f2 = '{8'h17, 8'h23, 8'h3A, 8'h41, 8'h5C, 8'h62, 8'h7F, 8'h80};
    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; frame_ack = 1'b0;

    // 1. reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_num0", num0, 0);
    check("rst_num7", num7, 0);
    check("rst_count", frame_count, 0);
    check("rst_len", frame_len, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // 2. full frame, no ack
    for (int i = 0; i < 8; i++) begin
      send(f2[i], 1'b0, 1'b0);
      if (i == 6) check("f2_not_yet_valid", frame_valid, 0);
    end
    check("f2_valid", frame_valid, 1);
    check("f2_num0", num0, 8'h17);
    check("f2_num3", num3, 8'h41);
    check("f2_num7", num7, 8'h80);
    check("f2_len", frame_len, 8);
    check("f2_count", frame_count, 1);

    // 3. ack, then short frame padded
    pulse_ack();
    check("ack_clears_valid", frame_valid, 0);
    check("ack_keeps_num0", num0, 8'h17);
    send(8'hA1, 1'b0, 1'b0);
    send(8'hB2, 1'b0, 1'b0);
    send(8'hC3, 1'b1, 1'b0);
    check("f3_valid", frame_valid, 1);
    check("f3_num0", num0, 8'hA1);
    check("f3_num2", num2, 8'hC3);
    check("f3_num3_pad", num3, 8'hFF);
    check("f3_num7_pad", num7, 8'hFF);
    check("f3_len", frame_len, 3);
    check("f3_count", frame_count, 2);

    // 4. second frame waits behind an unacked hold bank
    for (int i = 0; i < 8; i++) send(8'(i + 1), 1'b0, 1'b0);
    check("f4_in_ready_low", in_ready, 0);
    check("f4_hold_num0", num0, 8'hA1);
    check("f4_hold_len", frame_len, 3);
    send(8'hEE, 1'b0, 1'b0);
    check("f4_ignored_num0", num0, 8'hA1);
    check("f4_ignored_count", frame_count, 2);
    pulse_ack();
    check("f4_valid", frame_valid, 1);
    check("f4_num0", num0, 8'h01);
    check("f4_num7", num7, 8'h08);
    check("f4_len", frame_len, 8);
    check("f4_count", frame_count, 3);
    check("f4_in_ready", in_ready, 1);

    // 5. ack coincides with completion
    for (int i = 0; i < 8; i++) begin
      check("f5_in_ready", in_ready, 1);
      send(8'h21 + 8'(i), 1'b0, (i == 7));
    end
    check("f5_in_ready_after", in_ready, 1);
    check("f5_valid", frame_valid, 1);
    check("f5_num0", num0, 8'h21);
    check("f5_num7", num7, 8'h28);
    check("f5_count", frame_count, 4);

    // 6. reset mid-frame discards partial entries
    for (int i = 0; i < 4; i++) send(8'h31 + 8'(i), 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("r6_valid", frame_valid, 0);
    check("r6_count", frame_count, 0);
    check("r6_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send(8'h90 + 8'(i), 1'b0, 1'b0);
    check("f6_valid", frame_valid, 1);
    check("f6_num0", num0, 8'h90);
    check("f6_num4", num4, 8'h94);
    check("f6_num7", num7, 8'h97);
    check("f6_len", frame_len, 8);
    check("f6_count", frame_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
